demux1to4_dist: RTL and testbench
=================================

# demux1to4_dist

Registered 1-to-4 demultiplexer that distributes a single valid/ready input stream across four output lanes, each with a one-entry holding register and its own valid/ready handshake. It sits on the consumer side of the 4-to-1 multiplexer datapath and performs the inverse routing: one source fans out to four sinks. The target lane comes either from an explicit select (addressed mode) or from an internal round-robin pointer (distribute mode).

## Interface
- W, default 1, data width per lane in bits (≥1)
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  input beat present
- in_data  input  W  input beat payload
- in_sel  input  2  target lane in addressed mode; ignored when rr_mode=1
- rr_mode  input  1  0 = addressed (in_sel), 1 = round-robin (rr_ptr)
- in_ready  output  1  input beat is accepted this cycle if in_valid=1
- out_data  output  4*W  lane i payload at bits [i*W +: W]
- out_valid  output  4  lane i holding register full
- out_ready  input  4  lane i sink accepts this cycle
- rr_ptr  output  2  current round-robin lane

## Operation
- Target lane: t = rr_mode ? rr_ptr : in_sel. Combinational; rr_mode and in_sel changes affect t in the same cycle.
- in_ready = ~out_valid[t] | out_ready[t]. Combinational from out_valid, out_ready, t.
- Accept: fires when in_valid & in_ready.
  - On the next edge, lane t register loads in_data and out_valid[t] is set to 1.
- Pop: fires for lane i when out_valid[i] & out_ready[i].
  - On the next edge, out_valid[i] clears, unless lane i is loaded in the same cycle.
  - If a pop and a load hit the same lane in the same cycle, the new beat replaces the old one. out_valid stays 1 and no bubble appears.
- Holding: while out_valid[i]=1 and out_ready[i]=0, out_data lane i and out_valid[i] stay stable.
- Non-target lanes: never change on an accept. Pops on any lane proceed independently and concurrently.
- Round-robin pointer:
  - rr_ptr increments by 1 on each accept while rr_mode=1.
  - It wraps from 3 to 0 (2-bit modulo).
  - It holds when rr_mode=0, when there is no accept, or during a stall.
- Stall: in_valid=1 with in_ready=0 changes no state. The source holds its beat until acceptance.
- in_valid=0: no state changes except pops.
- No internal state machine beyond the four lane-full flags and rr_ptr. There is no drop or overflow path; back-pressure is the only flow control.

## Timing
- Reset values (asynchronous, immediate on rst=1): out_valid=4'b0000, out_data=all zeros, rr_ptr=2'b00.
  - in_ready=1 during and immediately after reset, since all lanes are empty.
- Reset mid-operation: any held beats are discarded and rr_ptr returns to 0. The first accept after rst deasserts goes to lane 0 in rr_mode.
- Latency: an accept in cycle N makes out_valid[t]=1 with the data in cycle N+1.
- Throughput:
  - Round-robin mode: one beat per cycle sustained, as long as each lane pops before its turn comes back.
  - Addressed mode, same lane every cycle: one beat per cycle only if that lane's out_ready=1 continuously.
- All outputs are registered except in_ready, which is combinational.

## Test plan
- Reset and addressed fill:
  - Stimulus: W=8, rst pulse, then out_ready=0, rr_mode=0, and beats 0xA0/0xA1/0xA2/0xA3 with in_sel=0/1/2/3 on consecutive cycles.
  - Required: out_valid=4'b1111 with lane i = 0xAi. A fifth beat with in_sel=2 sees in_ready=0, and no state changes.
- Round-robin wrap:
  - Stimulus: rr_mode=1, out_ready=4'b1111, six back-to-back beats 0x10..0x15.
  - Required: lanes receive 0,1,2,3,0,1 in order, each visible 1 cycle after its accept. rr_ptr ends at 2.
- Simultaneous pop and load:
  - Stimulus: lane 1 holds 0x55, out_ready[1]=1, and a new beat 0x66 targets lane 1 in the same cycle.
  - Required: in_ready=1, and the next cycle shows out_valid[1]=1 with out_data lane 1 = 0x66.
- Stall then release:
  - Stimulus: rr_mode=1, lane at rr_ptr full with out_ready=0, in_valid=1 with 0x77 held for 3 cycles, then out_ready asserted.
  - Required: rr_ptr and lane contents unchanged for 3 cycles. The beat is accepted on the release cycle, the lane shows 0x77 next cycle, and rr_ptr advances by 1.
- Asynchronous reset mid-stream:
  - Stimulus: rst asserted between clock edges while out_valid=4'b0110 and rr_ptr=3.
  - Required: out_valid=0, out_data=0, and rr_ptr=0 immediately, without waiting for a clock edge. After release, the next rr_mode beat lands in lane 0.

Source files
------------

// File: rtl/demux1to4_dist.sv
// Registered 1-to-4 demultiplexer: one valid/ready source fans out to four
// one-entry lane registers, steered by in_sel or by an internal round-robin pointer.
module demux1to4_dist #(
  parameter int unsigned W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  input  logic [1:0]     in_sel,
  input  logic           rr_mode,
  output logic           in_ready,
  output logic [4*W-1:0] out_data,
  output logic [3:0]     out_valid,
  input  logic [3:0]     out_ready,
  output logic [1:0]     rr_ptr
);

  localparam int unsigned LANES = 4;

  logic [LANES-1:0][W-1:0] r_data;
  logic [LANES-1:0]        r_valid;
  logic [1:0]              r_ptr;

  logic [1:0] w_tgt;
  logic       w_in_ready;
  logic       w_accept;

  // Target lane and acceptance; a full lane still accepts if it pops this cycle.
  always_comb begin
    w_tgt      = rr_mode ? r_ptr : in_sel;
    w_in_ready = ~r_valid[w_tgt] | out_ready[w_tgt];
    w_accept   = in_valid & w_in_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= '0;
      r_ptr   <= 2'b00;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        // A load wins over a pop on the same lane so no bubble appears.
        if (w_accept && (w_tgt == 2'(i))) begin
          r_data[i]  <= in_data;
          r_valid[i] <= 1'b1;
        end else if (out_ready[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
      if (w_accept && rr_mode) begin
        r_ptr <= r_ptr + 2'd1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign rr_ptr    = r_ptr;

endmodule

// File: tb/tb_demux1to4_dist.sv
// Directed scoreboard bench for demux1to4_dist with W=8.
module tb_demux1to4_dist;

  typedef struct packed {
    logic [1:0] lane;
    logic [7:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        rr_mode;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  rr_ptr;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [1:0] exp_ptr;

  demux1to4_dist #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .rr_mode   (rr_mode),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat for a cycle; on acceptance the expectation is queued and
  // retired against the lane contents one cycle later.
  task automatic beat(input logic rr, input logic [1:0] sel, input logic [7:0] d,
                      input logic exp_acc);
    exp_t e;
    logic [1:0] lane;
    rr_mode  = rr;
    in_sel   = sel;
    in_data  = d;
    in_valid = 1'b1;
    #1;
    lane = rr ? exp_ptr : sel;
    chk("in_ready", 32'(in_ready), 32'(exp_acc));
    if (exp_acc) begin
      sb.push_back('{lane, d});
      if (rr) exp_ptr = exp_ptr + 2'd1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (exp_acc) begin
      e = sb.pop_front();
      chk("lane_valid", 32'(out_valid[e.lane]), 32'd1);
      chk("lane_data", 32'(out_data[e.lane*8 +: 8]), 32'(e.data));
    end
    chk("rr_ptr", 32'(rr_ptr), 32'(exp_ptr));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_sel    = 2'd0;
    rr_mode   = 1'b0;
    out_ready = 4'b0000;
    exp_ptr   = 2'd0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_ptr", 32'(rr_ptr), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Addressed fill of all four lanes, then a stalled fifth beat.
    for (int i = 0; i < 4; i++) beat(1'b0, 2'(i), 8'hA0 + 8'(i), 1'b1);
    chk("fill_valid", 32'(out_valid), 32'hF);
    chk("fill_data", out_data, 32'hA3A2A1A0);
    beat(1'b0, 2'd2, 8'hBB, 1'b0);
    chk("stall_valid", 32'(out_valid), 32'hF);
    chk("stall_data", out_data, 32'hA3A2A1A0);

    // Round-robin wrap with all sinks ready.
    out_ready = 4'b1111;
    for (int i = 0; i < 6; i++) beat(1'b1, 2'd0, 8'h10 + 8'(i), 1'b1);
    chk("rr_end_ptr", 32'(rr_ptr), 32'd2);

    // Lane 1 holds 0x55, then pop and load 0x66 in the same cycle.
    out_ready = 4'b0010;
    beat(1'b0, 2'd1, 8'h55, 1'b1);
    out_ready = 4'b0000;
    @(posedge clk);
    #1;
    chk("hold_55", 32'(out_data[15:8]), 32'h55);
    chk("hold_valid", 32'(out_valid), 32'h2);
    out_ready = 4'b0010;
    beat(1'b0, 2'd1, 8'h66, 1'b1);
    chk("popload_valid", 32'(out_valid), 32'h2);
    out_ready = 4'b0000;

    // Fill lane 2 so the round-robin target is blocked, stall 3 cycles, release.
    beat(1'b0, 2'd2, 8'h22, 1'b1);
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 2'd0, 8'h77, 1'b0);
      chk("stall_lane2", 32'(out_data[23:16]), 32'h22);
      chk("stall_ptr", 32'(rr_ptr), 32'd2);
    end
    out_ready = 4'b0100;
    beat(1'b1, 2'd0, 8'h77, 1'b1);
    out_ready = 4'b0000;
    chk("pre_rst_valid", 32'(out_valid), 32'h6);
    chk("pre_rst_ptr", 32'(rr_ptr), 32'd3);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_ptr", 32'(rr_ptr), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    exp_ptr = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    beat(1'b1, 2'd3, 8'h99, 1'b1);
    chk("post_rst_lane0", 32'(out_valid), 32'h1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
